// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - request/grant bundle between requesters and the bus arbiter
//
// Ports (signals):
//   req      N     level request vector, bit i = requester i
//   gnt      N     one-hot grant, drives requester i send_en
//   gnt_id   ID_W  index of the current/last owner
//   busy     1     high exactly when gnt != 0
//   timeout  1     one-cycle pulse when a tenure is forcibly ended
// Modports: master = arbiter side, slave = requester side.

interface bus_rr_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            timeout;

    modport master (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin grant sequencer for the shared tri-state bus
//
// Ports:
//   clk   in   clock, all state updates on posedge
//   rst   in   synchronous reset, active-high
//   bus   master modport of bus_rr_arbiter_if (req in; gnt, gnt_id, busy,
//         timeout out, all registered)
// Grants are one-hot and feed the requesters' send_en directly. A tenure lasts
// at most MAX_HOLD cycles and every release is followed by one undriven
// turnaround cycle so two drivers never overlap.

module bus_rr_arbiter #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    bus_rr_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [N-1:0]      gnt_nxt;
    logic [ID_W-1:0]   gnt_id_nxt;
    logic              timeout_nxt;

    logic [N-1:0]      req_hi;
    logic [N-1:0]      search_vec;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;

    logic              owner_req;
    logic              hold_max;
    logic              release_now;

    // Rotating priority: requests at or above ptr are searched first; if none,
    // the wrap-around part (below ptr) is searched. Lowest index wins in each.
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = bus.req[i] && (ID_W'(i) >= ptr);
        end
        search_vec = (req_hi != '0) ? req_hi : bus.req;
        win_vld    = (bus.req != '0);
        win_id     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (search_vec[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // In GRANT, gnt is one-hot on the owner, so masking req with it yields the
    // owner's request without indexing by gnt_id.
    assign owner_req   = |(bus.req & bus.gnt);
    assign hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign release_now = !owner_req || hold_max;

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            bus.gnt     <= '0;
            bus.gnt_id  <= '0;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            bus.gnt     <= gnt_nxt;
            bus.gnt_id  <= gnt_id_nxt;
            bus.busy    <= |gnt_nxt;
            bus.timeout <= timeout_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = TURN;
            TURN:    state_nxt = win_vld ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic. TURN arbitrates exactly like IDLE; the dead
    // cycle comes from GRANT always passing through TURN with gnt cleared.
    always_comb begin
        gnt_nxt     = bus.gnt;
        gnt_id_nxt  = bus.gnt_id;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        case (state)
            GRANT: begin
                if (release_now) begin
                    gnt_nxt     = '0;
                    ptr_nxt     = (bus.gnt_id == ID_W'(N - 1)) ? '0 : bus.gnt_id + 1'b1;
                    timeout_nxt = hold_max && owner_req;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                gnt_nxt = '0;
                if (win_vld) begin
                    gnt_nxt    = N'(1) << win_id;
                    gnt_id_nxt = win_id;
                    hold_nxt   = '0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter (N=4 and N=3)

module tb_bus_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.N(4), .ID_W(2)) if4 ();
    bus_rr_arbiter_if #(.N(3), .ID_W(2)) if3 ();

    bus_rr_arbiter #(.N(4), .ID_W(2), .HOLD_W(4), .MAX_HOLD(MAX_HOLD)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    bus_rr_arbiter #(.N(3), .ID_W(2), .HOLD_W(4), .MAX_HOLD(MAX_HOLD)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 = bus free), cycles held so far, next
    // priority start, last owner, expected timeout pulse.
    int   n_of    [2] = '{4, 3};
    int   m_owner [2] = '{-1, -1};
    int   m_held  [2] = '{0, 0};
    int   m_pri   [2] = '{0, 0};
    int   m_last  [2] = '{0, 0};
    logic m_to    [2];
    logic [3:0] prev_gnt [2];
    int   wait_cnt [2][4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r, input logic rs);
        int n;
        int o;
        n = n_of[d];
        o = m_owner[d];
        m_to[d] = 1'b0;
        if (rs) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_pri[d]   = 0;
            m_last[d]  = 0;
        end else if (o >= 0) begin
            if (!r[o[1:0]] || m_held[d] == MAX_HOLD) begin
                m_to[d]    = (m_held[d] == MAX_HOLD) && r[o[1:0]];
                m_pri[d]   = (o + 1) % n;
                m_owner[d] = -1;
            end else begin
                m_held[d]++;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                int w;
                w = (m_pri[d] + k) % n;
                if (r[w[1:0]] && m_owner[d] < 0) begin
                    m_owner[d] = w;
                    m_held[d]  = 1;
                    m_last[d]  = w;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic to, input logic [3:0] r,
                             input logic rs);
        logic [3:0] exp_g;
        int o;
        int bound;
        o     = m_owner[d];
        exp_g = (o >= 0) ? (4'(1) << o) : 4'd0;
        bound = (n_of[d] - 1) * (MAX_HOLD + 1) + 1;
        chk($sformatf("d%0d_gnt", d), g, exp_g);
        chk($sformatf("d%0d_gnt_id", d), id, m_last[d]);
        chk($sformatf("d%0d_busy", d), b, o >= 0);
        chk($sformatf("d%0d_timeout", d), to, m_to[d]);
        chk($sformatf("d%0d_onehot", d), $onehot0(g), 1);
        chk($sformatf("d%0d_busy_or", d), b, |g);
        chk($sformatf("d%0d_gap", d), (g != 0 && prev_gnt[d] != 0 && g != prev_gnt[d]), 0);
        prev_gnt[d] = g;
        for (int i = 0; i < n_of[d]; i++) begin
            if (!rs && r[i] && !g[i]) wait_cnt[d][i]++;
            else wait_cnt[d][i] = 0;
            chk($sformatf("d%0d_starve%0d", d, i), wait_cnt[d][i] <= bound, 1);
        end
    endtask

    task automatic tick();
        logic [3:0] r4;
        logic [3:0] r3;
        logic       rs;
        r4 = if4.req;
        r3 = {1'b0, if3.req};
        rs = rst;
        @(posedge clk);
        model_step(0, r4, rs);
        model_step(1, r3, rs);
        #1;
        check_dut(0, if4.gnt, if4.gnt_id, if4.busy, if4.timeout, r4, rs);
        check_dut(1, {1'b0, if3.gnt}, if3.gnt_id, if3.busy, if3.timeout, r3, rs);
    endtask

    initial begin
        prev_gnt[0] = '0;
        prev_gnt[1] = '0;
        rst     = 1'b1;
        if4.req = 4'hF;
        if3.req = 3'b000;

        // Reset with all requests high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", if4.gnt, 4'b0000);
            chk("rst_busy", if4.busy, 1'b0);
            chk("rst_timeout", if4.timeout, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", if4.gnt, 4'b0001);

        // Single short request
        if4.req = 4'h0;
        tick();
        tick();
        if4.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("short_gnt", if4.gnt, 4'b0100);
        end
        if4.req = 4'h0;
        tick();
        chk("short_rel_gnt", if4.gnt, 4'b0000);
        chk("short_gnt_id", if4.gnt_id, 2'd2);
        chk("short_timeout", if4.timeout, 1'b0);

        // Round robin with all requests held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if4.req = 4'hF;
        tick();
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                chk("rr_gnt", if4.gnt, 4'(1) << (t % 4));
                tick();
            end
            chk("rr_dead_gnt", if4.gnt, 4'b0000);
            chk("rr_timeout", if4.timeout, 1'b1);
            tick();
        end

        // Reset in the 4th grant cycle of a tenure
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_gnt", if4.gnt, 4'b0000);
        chk("midrst_timeout", if4.timeout, 1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_first", if4.gnt, 4'b0001);

        // Early drop with requester 3 waiting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if4.req = 4'b1001;
        tick();
        chk("drop_gnt0", if4.gnt, 4'b0001);
        tick();
        chk("drop_gnt1", if4.gnt, 4'b0001);
        if4.req = 4'b1000;
        tick();
        chk("drop_dead", if4.gnt, 4'b0000);
        chk("drop_timeout", if4.timeout, 1'b0);
        tick();
        chk("drop_next", if4.gnt, 4'b1000);
        chk("drop_next_id", if4.gnt_id, 2'd3);

        // Wrap with N=3: ptr moved to 2, then requesters 0 and 2 held
        if4.req = 4'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if3.req = 3'b010;
        tick();
        chk("wrap_pre", if3.gnt, 3'b010);
        if3.req = 3'b000;
        tick();
        tick();
        if3.req = 3'b101;
        tick();
        chk("wrap_first", if3.gnt, 3'b100);
        chk("wrap_first_id", if3.gnt_id, 2'd2);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            chk("wrap_hold", if3.gnt, 3'b100);
        end
        tick();
        chk("wrap_dead", if3.gnt, 3'b000);
        chk("wrap_timeout", if3.timeout, 1'b1);
        tick();
        chk("wrap_second", if3.gnt, 3'b001);
        chk("wrap_second_id", if3.gnt_id, 2'd0);

        // Randomized: sticky request bits, occasional reset
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) if4.req[i] = ~if4.req[i];
            end
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) if3.req[i] = ~if3.req[i];
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
